// File: rtl/hwag_coil_channel.sv
// rtl/hwag_coil_channel.sv - ignition coil channel: angle-scheduled dwell and fire
// Optional dwell limit enabled by defining HWAG_COIL_DWELL_LIMIT_EN.
module hwag_coil_channel #(
  parameter int W  = 24,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hwag_start,
  input  logic          ena,
  input  logic [W-1:0]  acnt,
  input  logic [W-1:0]  acnt_top,
  input  logic          upd,
  input  logic [W-1:0]  ign_angle,
  input  logic [W-1:0]  acc_angle,
  input  logic [DW-1:0] max_dwell,
  output logic          coil_out,
  output logic          fire,
  output logic          busy,
  output logic          err_sync,
  output logic          err_dwell
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHARGE} state_t;

  state_t       state_q;
  logic [W-1:0] ign_sh_q, acc_sh_q, ign_q, acc_q;
  logic         coil_q, fire_q, err_sync_q;
  logic [W:0]   start_w;
  logic         acc_off, start_hit, ign_hit, dwell_hit;

  // Start angle wraps back through acnt_top when the dwell spans the cycle boundary.
  always_comb begin
    start_w = '0;
    if (ign_q >= acc_q)
      start_w = {1'b0, ign_q} - {1'b0, acc_q};
    else
      start_w = {1'b0, ign_q} + {1'b0, acnt_top} + (W+1)'(1) - {1'b0, acc_q};
  end

  assign acc_off   = (acc_q == '0) || (acc_q > acnt_top);
  assign start_hit = !acc_off && ({1'b0, acnt} == start_w) && (start_w != {1'b0, ign_q});
  assign ign_hit   = (acnt == ign_q);

`ifdef HWAG_COIL_DWELL_LIMIT_EN
  logic [DW-1:0] dwell_q, dwell_d;
  logic          err_dwell_q;

  assign dwell_d   = dwell_q + DW'(1);
  assign dwell_hit = (max_dwell != '0) && (dwell_d == max_dwell);

  always_ff @(posedge clk) begin
    if (rst || state_q != S_CHARGE) dwell_q <= '0;
    else                            dwell_q <= dwell_d;
  end

  always_ff @(posedge clk) begin
    if (rst)
      err_dwell_q <= 1'b0;
    else if (state_q == S_CHARGE && ena && hwag_start && !ign_hit && dwell_hit)
      err_dwell_q <= 1'b1;
  end

  assign err_dwell = err_dwell_q;
`else
  logic unused_max_dwell;
  assign unused_max_dwell = ^max_dwell;
  assign dwell_hit        = 1'b0;
  assign err_dwell        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ign_sh_q <= '0;
      acc_sh_q <= '0;
    end else if (upd) begin
      ign_sh_q <= ign_angle;
      acc_sh_q <= acc_angle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      coil_q     <= 1'b0;
      fire_q     <= 1'b0;
      err_sync_q <= 1'b0;
      ign_q      <= '0;
      acc_q      <= '0;
    end else begin
      fire_q <= 1'b0;
      if (!ena) begin
        state_q <= S_IDLE;
        coil_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (hwag_start) begin
              state_q <= S_WAIT;
              ign_q   <= ign_sh_q;
              acc_q   <= acc_sh_q;
            end
          end
          S_WAIT: begin
            if (!hwag_start) begin
              state_q <= S_IDLE;
            end else if (start_hit) begin
              state_q <= S_CHARGE;
              coil_q  <= 1'b1;
            end
          end
          S_CHARGE: begin
            // Losing sync mid-charge aborts without a spark; the coil is just released.
            if (!hwag_start) begin
              state_q    <= S_IDLE;
              coil_q     <= 1'b0;
              err_sync_q <= 1'b1;
            end else if (ign_hit || dwell_hit) begin
              state_q <= S_WAIT;
              coil_q  <= 1'b0;
              fire_q  <= 1'b1;
              ign_q   <= ign_sh_q;
              acc_q   <= acc_sh_q;
            end
          end
          default: begin
            state_q <= S_IDLE;
            coil_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign coil_out = coil_q;
  assign fire     = fire_q;
  assign busy     = (state_q != S_IDLE);
  assign err_sync = err_sync_q;

endmodule

// File: tb/tb_hwag_coil_channel.sv
// tb/tb_hwag_coil_channel.sv - randomized and directed bench for hwag_coil_channel
module tb_hwag_coil_channel;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hwag_start = 1'b0;
  logic        ena = 1'b0;
  logic        upd = 1'b0;
  logic [23:0] acnt = '0;
  logic [23:0] acnt_top = 24'd239;
  logic [23:0] ign_angle = '0;
  logic [23:0] acc_angle = '0;
  logic [23:0] max_dwell = '0;
  logic        coil_out, fire, busy, err_sync, err_dwell;

  int total = 0;
  int bad = 0;

`ifdef HWAG_COIL_DWELL_LIMIT_EN
  localparam bit DWELL_ON = 1'b1;
`else
  localparam bit DWELL_ON = 1'b0;
`endif

  hwag_coil_channel #(.W(24), .DW(24)) dut (
    .clk(clk), .rst(rst), .hwag_start(hwag_start), .ena(ena),
    .acnt(acnt), .acnt_top(acnt_top), .upd(upd),
    .ign_angle(ign_angle), .acc_angle(acc_angle), .max_dwell(max_dwell),
    .coil_out(coil_out), .fire(fire), .busy(busy),
    .err_sync(err_sync), .err_dwell(err_dwell)
  );

  always #5 clk = ~clk;

  // Reference: engaged = synchronised and enabled, charging = coil energised.
  int m_ign_sh, m_acc_sh, m_ign, m_acc, m_len;
  bit m_on, m_chg, m_coil, m_fire, m_es, m_ed;
  int diverge;
  bit prev_coil;
  int rise_q[$];
  int fire_q[$];

  task automatic model_step();
    int top, a, start, sh_i, sh_a;
    top  = int'(acnt_top);
    a    = int'(acnt);
    sh_i = m_ign_sh;
    sh_a = m_acc_sh;
    if (rst) begin
      m_ign_sh = 0; m_acc_sh = 0; m_ign = 0; m_acc = 0; m_len = 0;
      m_on = 0; m_chg = 0; m_coil = 0; m_fire = 0; m_es = 0; m_ed = 0;
    end else begin
      m_fire = 0;
      if (!ena) begin
        m_on = 0; m_chg = 0; m_coil = 0;
      end else if (!m_on) begin
        if (hwag_start) begin
          m_on = 1; m_ign = sh_i; m_acc = sh_a;
        end
      end else if (!hwag_start) begin
        if (m_chg) m_es = 1;
        m_on = 0; m_chg = 0; m_coil = 0;
      end else if (m_chg) begin
        m_len++;
        if (a == m_ign || (DWELL_ON && max_dwell != 0 && m_len == int'(max_dwell))) begin
          if (a != m_ign) m_ed = 1;
          m_fire = 1; m_coil = 0; m_chg = 0; m_ign = sh_i; m_acc = sh_a;
        end
      end else begin
        start = (m_ign - m_acc + top + 1) % (top + 1);
        if (m_acc != 0 && m_acc <= top && a == start) begin
          m_chg = 1; m_coil = 1; m_len = 0;
        end
      end
      if (upd) begin
        m_ign_sh = int'(ign_angle);
        m_acc_sh = int'(acc_angle);
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    if ({coil_out, fire, busy, err_sync, err_dwell} !== {m_coil, m_fire, m_on, m_es, m_ed})
      diverge++;
    if (coil_out && !prev_coil) rise_q.push_back(int'(acnt));
    if (fire) fire_q.push_back(int'(acnt));
    prev_coil = coil_out;
  endtask

  task automatic arm(input int ign, input int acc, input int top);
    acnt_top = 24'(top);
    ena = 1'b0; hwag_start = 1'b0; upd = 1'b1;
    ign_angle = 24'(ign); acc_angle = 24'(acc);
    step();
    upd = 1'b0; ena = 1'b1; hwag_start = 1'b1; acnt = 24'(top);
    step();
    diverge = 0;
    rise_q.delete();
    fire_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; hwag_start = 1'b1; upd = 1'b1;
    ign_angle = 24'd50; acc_angle = 24'd10;
    step();
    step();
    total++;
    if ({coil_out, fire, busy, err_sync, err_dwell} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=00000", {coil_out, fire, busy, err_sync, err_dwell});
    end
    rst = 1'b0; upd = 1'b0; ena = 1'b0; hwag_start = 1'b0;
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy=%b want=0", busy);
    end
  endtask

  task automatic test_normal_fire();
    arm(100, 20, 239);
    for (int a = 0; a <= 239; a++) begin
      acnt = 24'(a);
      step();
    end
    total++;
    if (rise_q.size() != 1 || rise_q[0] != 80) begin
      bad++;
      $display("FAIL normal_rise count=%0d first=%0d want one at 80", rise_q.size(),
               rise_q.size() > 0 ? rise_q[0] : -1);
    end
    total++;
    if (fire_q.size() != 1 || fire_q[0] != 100) begin
      bad++;
      $display("FAIL normal_fire count=%0d first=%0d want one at 100", fire_q.size(),
               fire_q.size() > 0 ? fire_q[0] : -1);
    end
    total++;
    if (diverge != 0) begin
      bad++;
      $display("FAIL normal_model diverge=%0d want=0", diverge);
    end
  endtask

  task automatic test_wrap();
    arm(10, 30, 239);
    for (int i = 0; i < 240; i++) begin
      acnt = 24'((200 + i) % 240);
      step();
    end
    total++;
    if (rise_q.size() != 1 || rise_q[0] != 220 || fire_q.size() != 1 || fire_q[0] != 10) begin
      bad++;
      $display("FAIL wrap_events rises=%0d fires=%0d want rise 220 fire 10", rise_q.size(), fire_q.size());
    end
    total++;
    if (diverge != 0) begin
      bad++;
      $display("FAIL wrap_model diverge=%0d want=0", diverge);
    end
  endtask

  task automatic test_shadow();
    arm(100, 20, 239);
    for (int a = 0; a <= 239; a++) begin
      acnt = 24'(a);
      upd = (a == 90);
      ign_angle = 24'd150; acc_angle = 24'd20;
      step();
    end
    upd = 1'b0;
    total++;
    if (rise_q.size() != 2 || rise_q[0] != 80 || rise_q[1] != 130) begin
      bad++;
      $display("FAIL shadow_rises count=%0d want 80,130", rise_q.size());
    end
    total++;
    if (fire_q.size() != 2 || fire_q[0] != 100 || fire_q[1] != 150) begin
      bad++;
      $display("FAIL shadow_fires count=%0d want 100,150", fire_q.size());
    end
    total++;
    if (diverge != 0) begin
      bad++;
      $display("FAIL shadow_model diverge=%0d want=0", diverge);
    end
  endtask

  task automatic test_sync_loss();
    arm(100, 20, 239);
    for (int a = 0; a < 90; a++) begin
      acnt = 24'(a);
      step();
    end
    acnt = 24'd90; hwag_start = 1'b0;
    step();
    total++;
    if ({coil_out, fire, err_sync, busy} !== 4'b0010 || fire_q.size() != 0) begin
      bad++;
      $display("FAIL sync_loss got coil,fire,err_sync,busy=%b want=0010", {coil_out, fire, err_sync, busy});
    end
    for (int i = 0; i < 5; i++) step();
    total++;
    if (err_sync !== 1'b1) begin
      bad++;
      $display("FAIL sync_sticky err_sync=%b want=1", err_sync);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (err_sync !== 1'b0) begin
      bad++;
      $display("FAIL sync_clear err_sync=%b want=0", err_sync);
    end
  endtask

  task automatic test_abort();
    arm(100, 20, 239);
    for (int a = 0; a < 85; a++) begin
      acnt = 24'(a);
      step();
    end
    ena = 1'b0;
    step();
    total++;
    if ({coil_out, fire, busy, err_sync, err_dwell} !== 5'b0) begin
      bad++;
      $display("FAIL ena_drop got=%b want=00000", {coil_out, fire, busy, err_sync, err_dwell});
    end
    arm(100, 20, 239);
    for (int a = 0; a < 85; a++) begin
      acnt = 24'(a);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({coil_out, busy} !== 2'b00) begin
      bad++;
      $display("FAIL rst_mid_charge coil,busy=%b want=00", {coil_out, busy});
    end
  endtask

  task automatic test_dwell_limit();
    int hi_run, exp_run, exp_fire, exp_ed, fires;
    bit counting;
    exp_run  = DWELL_ON ? 5 : 21;
    exp_fire = DWELL_ON ? 1 : 0;
    exp_ed   = DWELL_ON ? 1 : 0;
    max_dwell = 24'd5;
    arm(100, 20, 239);
    for (int a = 0; a <= 80; a++) begin
      acnt = 24'(a);
      step();
    end
    hi_run = coil_out ? 1 : 0;
    counting = coil_out;
    fires = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (counting && coil_out) hi_run++;
      else counting = 0;
      if (fire && fires == 0) fires = 1;
    end
    total++;
    if (hi_run != exp_run) begin
      bad++;
      $display("FAIL dwell_high_cycles got=%0d want=%0d", hi_run, exp_run);
    end
    total++;
    if (fires != exp_fire || int'(err_dwell) != exp_ed) begin
      bad++;
      $display("FAIL dwell_forced fire=%0d err_dwell=%b want fire=%0d err_dwell=%0d",
               fires, err_dwell, exp_fire, exp_ed);
    end
    total++;
    if (diverge != 0) begin
      bad++;
      $display("FAIL dwell_model diverge=%0d want=0", diverge);
    end
    rst = 1'b1; max_dwell = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_acc_off();
    int accs[2] = '{0, 300};
    foreach (accs[k]) begin
      arm(100, accs[k], 239);
      for (int i = 0; i < 480; i++) begin
        acnt = 24'(i % 240);
        step();
      end
      total++;
      if (rise_q.size() != 0 || fire_q.size() != 0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL acc_off acc=%0d rises=%0d fires=%0d busy=%b want 0,0,1",
                 accs[k], rise_q.size(), fire_q.size(), busy);
      end
    end
  endtask

  task automatic test_random();
    int top, a;
    top = $urandom_range(20, 60);
    arm($urandom_range(0, top), $urandom_range(1, top), top);
    a = 0;
    for (int i = 0; i < 4000; i++) begin
      acnt       = 24'(a);
      upd        = ($urandom_range(0, 19) == 0);
      ign_angle  = 24'($urandom_range(0, top));
      acc_angle  = 24'($urandom_range(0, top + 8));
      hwag_start = ($urandom_range(0, 59) != 0);
      ena        = ($urandom_range(0, 89) != 0);
      rst        = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) == 0) max_dwell = 24'($urandom_range(0, 40));
      step();
      a = (a == top) ? 0 : a + 1;
    end
    rst = 1'b0; upd = 1'b0;
    total++;
    if (diverge != 0) begin
      bad++;
      $display("FAIL random_model diverge=%0d want=0 top=%0d", diverge, top);
    end
  endtask

  initial begin
    diverge = 0;
    prev_coil = 1'b0;
    test_reset();
    test_normal_fire();
    test_wrap();
    test_shadow();
    test_sync_loss();
    test_abort();
    test_dwell_limit();
    test_acc_off();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hwag_coil_channel.md
HWAG_COIL_CHANNEL -- requirements
Module: hwag_coil_channel

Interface
REQ-001 The block SHALL have parameter W, default 24, giving the angle width in bits.
REQ-002 The block SHALL have parameter DW, default 24, giving the dwell-limit counter width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port hwag_start, input, 1 bit: angle generator synchronised.
REQ-006 The block SHALL have port ena, input, 1 bit: channel enable.
REQ-007 The block SHALL have port acnt, input, W bits: current angle count (ACNT2 domain), 0..acnt_top.
REQ-008 The block SHALL have port acnt_top, input, W bits: last angle value of one cycle.
REQ-009 The block SHALL have port upd, input, 1 bit: one-cycle strobe that latches ign_angle and acc_angle into shadow registers.
REQ-010 The block SHALL have port ign_angle, input, W bits: fire angle.
REQ-011 The block SHALL have port acc_angle, input, W bits: accumulation (dwell) angle.
REQ-012 The block SHALL have port max_dwell, input, DW bits: dwell limit in clk cycles.
REQ-013 The block SHALL have port coil_out, output, 1 bit, registered: coil drive.
REQ-014 The block SHALL have port fire, output, 1 bit: one-cycle fire pulse.
REQ-015 The block SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-016 The block SHALL have port err_sync, output, 1 bit: sticky; charge aborted by loss of sync.
REQ-017 The block SHALL have port err_dwell, output, 1 bit: sticky; forced fire on dwell limit.

Function
REQ-018 Shadow and active registers SHALL behave as follows.
- upd latches ign_angle and acc_angle into shadow registers.
- Shadow copies to active on entry to WAIT: from IDLE, or after a fire.
- upd during CHARGE affects only the next cycle.
REQ-019 The start angle SHALL be computed from active values.
- start = ign - acc when ign >= acc.
- Otherwise start = ign + acnt_top + 1 - acc, computed at W+1 bits.
REQ-020 States SHALL be IDLE, WAIT and CHARGE, with these transitions.
- IDLE -> WAIT when ena & hwag_start.
- WAIT -> CHARGE when acnt == start and acc != 0.
- CHARGE -> WAIT when acnt == ign (normal fire).
REQ-021 A fire SHALL drive fire = 1 for exactly one cycle, drive coil_out to 0, and reload active from shadow.
REQ-022 The block SHALL register its outputs with these latencies.
- The match cycle n SHALL raise coil_out at n+1.
- The fire match SHALL drop coil_out and raise fire at n+1.
REQ-023 acc == 0 SHALL mean the channel never charges and stays in WAIT with coil_out = 0.
REQ-024 acc > acnt_top SHALL be treated as acc == 0.
REQ-025 If start and ign match on the same cycle (acc == acnt_top + 1), the channel SHALL take no action.
REQ-026 When hwag_start falls in CHARGE, the block SHALL:
- go to IDLE next cycle with coil_out = 0;
- produce no fire pulse;
- set err_sync.
REQ-027 When hwag_start falls in WAIT, the block SHALL go to IDLE with no flag.
REQ-028 When ena falls in any state, the block SHALL go to IDLE next cycle with coil_out = 0, no fire and no flag.
REQ-029 acnt wrap (acnt_top -> 0) SHALL need no special handling; equality compare only.
REQ-030 A start match SHALL be ignored while the channel is in CHARGE.
REQ-031 err_sync and err_dwell SHALL be cleared only by rst.

Reset
REQ-032 On rst, the block SHALL set:
- state = IDLE;
- coil_out = 0, fire = 0;
- err_sync = 0, err_dwell = 0;
- shadow and active registers = 0;
- dwell counter = 0.
REQ-033 rst SHALL take priority over every other input.
REQ-034 rst mid-CHARGE SHALL drop coil_out on the next cycle.

Configuration
REQ-035 With HWAG_COIL_DWELL_LIMIT_EN defined, the block SHALL provide a dwell limit.
- A DW-bit counter clears on CHARGE entry and increments each CHARGE cycle.
- At count == max_dwell the block performs a forced fire: fire pulse, coil_out = 0, err_dwell set, -> WAIT.
- max_dwell == 0 disables the limit.
REQ-036 Without HWAG_COIL_DWELL_LIMIT_EN, the block SHALL omit the counter, ignore max_dwell, and tie err_dwell to 0.

Verification
REQ-037 Normal fire: top = 239, upd with ign = 100, acc = 20, acnt stepping by 1 -> coil_out rises the cycle after acnt == 80, falls with a one-cycle fire the cycle after acnt == 100.
REQ-038 Wrap: top = 239, ign = 10, acc = 30 -> charge from acnt == 220 across the 239->0 wrap, fire after acnt == 10.
REQ-039 Shadow timing: upd ign = 150 at acnt == 90, mid-CHARGE of ign = 100 -> this cycle fires at 100, the next charges at 130 and fires at 150.
REQ-040 Sync loss: drop hwag_start at acnt == 90, in CHARGE -> coil_out = 0 next cycle, no fire, err_sync = 1, busy = 0.
REQ-041 Dwell limit (macro on): max_dwell = 5, acnt frozen after start match -> coil high 5 cycles, forced fire, err_dwell = 1. With the macro off: coil stays high, err_dwell = 0.
REQ-042 acc = 0 and acc = 300 (> top): a full revolution -> coil_out never rises, no fire.
